// File: rtl/hbridge_pwm_ctrl_pkg.sv
// Shared types and constants for the H-bridge PWM controller.
// Holds the channel state encoding, the gate drive patterns and the dead-counter sizing helper.
package hbridge_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2,
    ST_DEAD  = 2'd3
  } ch_state_e;

  localparam logic [3:0] FWD = 4'b1001;
  localparam logic [3:0] REV = 4'b0110;
  localparam logic [3:0] OFF = 4'b0000;

  // The dead counter runs 0 .. DEAD_CYCLES-1, so it needs clog2(DEAD_CYCLES) bits (at least 1).
  function automatic int dead_cnt_w(input int dead_cycles);
    return (dead_cycles < 2) ? 1 : $clog2(dead_cycles);
  endfunction

endpackage

// File: rtl/hbridge_pwm_channel.sv
// One H-bridge channel: state machine, per-period duty ramp, dead-time counter and registered gate output.
// The compare uses next-state duty so the value seen at counter 0 already belongs to the new period.
module hbridge_pwm_channel
  import hbridge_pwm_ctrl_pkg::*;
#(
  parameter int CNT_W       = 17,
  parameter int DUTY_W      = 8,
  parameter int RAMP_STEP   = 4,
  parameter int DEAD_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              en_i,
  input  logic              dir_cmd_i,
  input  logic [DUTY_W-1:0] duty_cmd_i,
  output logic [3:0]        in_o,
  output logic [DUTY_W-1:0] duty_cur_o,
  output logic              busy_o,
  output ch_state_e         state_o
);

  localparam int              DCW       = dead_cnt_w(DEAD_CYCLES);
  localparam logic [DCW-1:0]  DEAD_LAST = DCW'(DEAD_CYCLES - 1);
  localparam int              SHIFT     = CNT_W - DUTY_W;

  ch_state_e         state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [DCW-1:0]    dead_q, dead_d;
  logic [3:0]        in_q, in_d;
  logic              stop;
  logic              drive;
  logic [CNT_W-1:0]  cmp;

  // Move cur toward tgt by at most RAMP_STEP, never past it.
  function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur,
                                             input logic [DUTY_W-1:0] tgt);
    int c;
    int t;
    int r;
    c = int'(cur);
    t = int'(tgt);
    if (t > c) r = ((t - c) > RAMP_STEP) ? c + RAMP_STEP : t;
    else       r = ((c - t) > RAMP_STEP) ? c - RAMP_STEP : t;
    return DUTY_W'(r);
  endfunction

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    stop    = !en_i || (dir_cmd_i != dir_q);
    case (state_q)
      ST_IDLE: begin
        if (en_i && (duty_cmd_i != '0)) begin
          state_d = ST_RUN;
          dir_d   = dir_cmd_i;
          if (tick_i) duty_d = ramp(duty_q, duty_cmd_i);
        end
      end
      ST_RUN: begin
        // Commands are only sampled at the period boundary, so a toggle cannot cut a pulse short.
        if (tick_i) begin
          if (stop) begin
            state_d = ST_DECEL;
            duty_d  = ramp(duty_q, '0);
          end else begin
            duty_d  = ramp(duty_q, duty_cmd_i);
          end
        end
      end
      ST_DECEL: begin
        if (duty_q == '0) begin
          state_d = ST_DEAD;
          dead_d  = '0;
        end else if (tick_i) begin
          duty_d  = ramp(duty_q, '0);
        end
      end
      ST_DEAD: begin
        if (dead_q == DEAD_LAST) begin
          state_d = ST_IDLE;
          dead_d  = '0;
        end else begin
          dead_d  = dead_q + DCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmp   = CNT_W'(duty_d) << SHIFT;
    drive = ((state_d == ST_RUN) || (state_d == ST_DECEL)) && (cnt_i < cmp);
    in_d  = drive ? (dir_d ? FWD : REV) : OFF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b1;
      dead_q  <= '0;
      in_q    <= OFF;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      in_q    <= in_d;
    end
  end

  assign in_o       = in_q;
  assign duty_cur_o = duty_q;
  assign busy_o     = (state_q == ST_DECEL) || (state_q == ST_DEAD);
  assign state_o    = state_q;

endmodule

// File: rtl/hbridge_pwm_ctrl.sv
// Multi-channel H-bridge PWM controller: one shared period counter feeding NUM_CH channels.
// state_dbg carries each channel's state, channel k in bits [2k +: 2].
module hbridge_pwm_ctrl
  import hbridge_pwm_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 17,
  parameter int DUTY_W      = 8,
  parameter int RAMP_STEP   = 4,
  parameter int DEAD_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        en,
  input  logic [NUM_CH-1:0]        dir_cmd,
  input  logic [NUM_CH*DUTY_W-1:0] duty_cmd,
  output logic [4*NUM_CH-1:0]      IN,
  output logic [NUM_CH*DUTY_W-1:0] duty_cur,
  output logic [NUM_CH-1:0]        busy,
  output logic                     period_tick,
  output logic [2*NUM_CH-1:0]      state_dbg
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  ch_state_e        ch_state [NUM_CH];

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The counter sits at 0 during reset, so the tick is masked until reset releases.
  assign tick        = (cnt_q == '0);
  assign period_tick = tick & ~reset;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    hbridge_pwm_channel #(
      .CNT_W       (CNT_W),
      .DUTY_W      (DUTY_W),
      .RAMP_STEP   (RAMP_STEP),
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (reset),
      .tick_i     (tick),
      .cnt_i      (cnt_q),
      .en_i       (en[k]),
      .dir_cmd_i  (dir_cmd[k]),
      .duty_cmd_i (duty_cmd[k*DUTY_W +: DUTY_W]),
      .in_o       (IN[4*k +: 4]),
      .duty_cur_o (duty_cur[k*DUTY_W +: DUTY_W]),
      .busy_o     (busy[k]),
      .state_o    (ch_state[k])
    );
    assign state_dbg[2*k +: 2] = ch_state[k];
  end

endmodule

// File: doc/hbridge_pwm_ctrl.md
HBRIDGE_PWM_CTRL -- requirements
Module: hbridge_pwm_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent H-bridge channels.
REQ-002 Parameter CNT_W, default 17: PWM counter width, period 2^CNT_W clocks (~762 Hz at 100 MHz).
REQ-003 Parameter DUTY_W, default 8: duty command width, DUTY_W <= CNT_W.
REQ-004 Parameter RAMP_STEP, default 4: maximum duty change per PWM period.
REQ-005 Parameter DEAD_CYCLES, default 1024: clocks of all-off between a stop and reversed drive.
REQ-006 clk  input  1  single system clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 en  input  NUM_CH  per-channel enable; 0 forces a controlled ramp to stop.
REQ-009 dir_cmd  input  NUM_CH  per-channel direction command, 1 = forward, 0 = reverse.
REQ-010 duty_cmd  input  NUM_CH*DUTY_W  per-channel target duty; channel k occupies bits [k*DUTY_W +: DUTY_W].
REQ-011 IN  output  4*NUM_CH  H-bridge gate pattern; channel k occupies bits [4k +: 4].
REQ-012 duty_cur  output  NUM_CH*DUTY_W  per-channel applied duty after ramping.
REQ-013 busy  output  NUM_CH  1 while the channel is in DECEL or DEAD.
REQ-014 period_tick  output  1  one-clock pulse when the PWM counter wraps to 0.

Function
REQ-015 One free-running CNT_W-bit counter, shared by all channels, increments every clock and wraps from 2^CNT_W-1 to 0; period_tick is high in the cycle the counter equals 0.
REQ-016 Channel drives when counter < (duty_cur << (CNT_W-DUTY_W)); duty_cur = 0 gives 0 % duty, and the maximum duty is (2^DUTY_W-1)/2^DUTY_W.
REQ-017 Drive pattern: forward = 4'b1001, reverse = 4'b0110, off = 4'b0000; patterns 4'b1111, 4'b1100 and 4'b0011 are never emitted.
REQ-018 IN is registered and reflects the compare result from the previous clock (1-cycle latency).
REQ-019 Per-channel FSM states:
- IDLE: duty_cur = 0, output off.
- RUN: driving in the latched direction (dir_lat).
- DECEL: ramping to 0 before a reversal or stop.
- DEAD: all-off countdown.
REQ-020 IDLE -> RUN when en = 1 and duty_cmd != 0; dir_lat latches dir_cmd on entry.
REQ-021 RUN -> DECEL when dir_cmd != dir_lat, or when en = 0.
REQ-022 DECEL -> DEAD when duty_cur reaches 0.
REQ-023 DEAD -> IDLE after DEAD_CYCLES clocks, with outputs off throughout.
REQ-024 Ramp update happens only on period_tick, in RUN or DECEL.
REQ-025 Ramp target: duty_cmd in RUN, 0 in DECEL.
REQ-026 Each ramp update moves duty_cur toward the target by min(RAMP_STEP, |target - duty_cur|); no overshoot, no wrap.
REQ-027 duty_cmd changes and dir_cmd toggles mid-period take effect only at the next period_tick; the compare value is stable within a period, so there are no runt pulses.
REQ-028 dir_cmd toggling back during DECEL or DEAD does not abort the sequence; the channel completes DEAD, then re-evaluates from IDLE.
REQ-029 en = 0 in IDLE keeps the channel in IDLE.
REQ-030 Simultaneous en = 0 and a direction change is treated as a single DECEL.
REQ-031 Channels are fully independent except for the shared counter.

Reset
REQ-032 On reset assertion, asynchronously:
- counter = 0
- all FSMs = IDLE
- duty_cur = 0
- dir_lat = 1
- dead counters = 0
- IN = 0
- busy = 0
- period_tick = 0
REQ-033 Reset mid-DECEL or mid-DEAD forces IN = 0 immediately; after deassertion, the first tick is counter = 0 on the first clock edge.

Structure
REQ-034 A shared package holds:
- the FSM state enum;
- drive pattern constants (FWD = 4'b1001, REV = 4'b0110, OFF = 4'b0000);
- a function computing the dead-counter width from DEAD_CYCLES.
REQ-035 A sub-module hbridge_pwm_channel implements one channel (FSM, ramp, dead counter, output register); the top holds the counter and a generate loop of NUM_CH instances.

Verification
REQ-036 Use small parameters for simulation: CNT_W = 8, DUTY_W = 4, RAMP_STEP = 2, DEAD_CYCLES = 5, NUM_CH = 2.
REQ-037 Ramp up: ch0 en = 1, dir = 1, duty_cmd = 8 from IDLE -> duty_cur reads 2, 4, 6, 8 on successive period_ticks; at duty 8 IN[3:0] = 1001 for 128 of 256 clocks.
REQ-038 Reversal: ch0 in RUN at duty 8, dir_cmd -> 0:
- duty ramps 6, 4, 2, 0;
- IN[3:0] = 0000 for at least 5 clocks with busy = 1;
- then 0110 appears;
- no cycle shows 1001 adjacent to 0110.
REQ-039 Odd step: duty_cmd = 7 from 0 -> duty_cur 2, 4, 6, 7 (clamped, no overshoot).
REQ-040 Independence: ch0 forward duty 15 and ch1 reverse duty 4 run concurrently -> ch0 is high 240/256 clocks and ch1 (IN[7:4] = 0110) is high 64/256 clocks.
REQ-041 Async reset: assert reset mid-DEAD without a clock edge -> IN = 0 and busy = 0 at once; after release, counter restarts at 0 and the FSM is in IDLE.
REQ-042 Mid-period change: change duty_cmd at counter = 100 -> pulse widths in the current period are unchanged and the new duty applies from the next period_tick.
